bitstream_collector: RTL

- Receiver side of the entropy encoder's bitstream output interface.
- Accepts the two per-cycle output lanes of entropy_encoder; each lane is a 3-bit flag plus five 8-bit fields.
- Buffers the lane descriptors in a descriptor FIFO and expands each one into an ordered byte stream with a valid/ready handshake.
- Feeds the file writer, and the bench compares its output directly against the reference bitstream.

---
 rtl/bitstream_pkg.sv | 33 +++
 rtl/desc_fifo.sv | 48 ++++
 rtl/bitstream_collector.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bitstream_pkg.sv
// Shared types for the bitstream collector: lane descriptor, flag codes, expansion FSM states.
package bitstream_pkg;

  localparam logic [2:0] FLAG_NONE    = 3'd0;
  localparam logic [2:0] FLAG_ILLEGAL = 3'd4;
  localparam logic [2:0] FLAG_RUN_MIN = 3'd5;
  localparam logic [2:0] FLAG_TAIL4   = 3'd6;
  localparam logic [2:0] FLAG_TAIL5   = 3'd7;

  typedef struct packed {
    logic [2:0] flag;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    logic [7:0] b4;
    logic [7:0] b5;
  } lane_desc_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StEmitB1,
    StEmitDir,
    StEmitRun,
    StEmitB4,
    StEmitB5
  } state_e;

  function automatic logic lane_legal(input logic [2:0] f);
    return (f != FLAG_NONE) && (f != FLAG_ILLEGAL);
  endfunction

endpackage

// File: rtl/desc_fifo.sv
// Dual-write, single-read descriptor FIFO with free-entry count.
// Port 1 is only written together with port 0 and lands in the following slot.
module desc_fifo
  import bitstream_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             bool_burst_1,
  input  logic             wr_en_0,
  input  lane_desc_t       wr_data_0,
  input  logic             wr_en_1,
  input  lane_desc_t       wr_data_1,
  input  logic             rd_en,
  output lane_desc_t       rd_data,
  output logic             empty,
  output logic [CNT_W-1:0] free_cnt
);

  lane_desc_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_p1;
  logic [CNT_W-1:0] count_q;

  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
  assign rd_data   = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign free_cnt  = CNT_W'(DEPTH) - count_q;

  always_ff @(posedge clk) begin
    if (wr_en_0) mem_q[wr_ptr_q] <= wr_data_0;
    if (wr_en_1) mem_q[wr_ptr_p1] <= wr_data_1;
  end

  always_ff @(posedge clk or posedge bool_burst_1) begin
    if (bool_burst_1) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(wr_en_0) + PTR_W'(wr_en_1);
      rd_ptr_q <= rd_ptr_q + PTR_W'(rd_en);
      count_q  <= count_q + CNT_W'(wr_en_0) + CNT_W'(wr_en_1) - CNT_W'(rd_en);
    end
  end

endmodule

// File: rtl/bitstream_collector.sv
// Collects two entropy-encoder lanes into a descriptor FIFO and expands them into a byte stream.
// Optional byte counter enabled by COLLECTOR_COUNT_EN.
module bitstream_collector
  import bitstream_pkg::*;
#(
  parameter int unsigned BITSTREAM_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned COUNT_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       bool_burst_1,
  input  logic [2:0]                 in_flag_1,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_1_1,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_1_2,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_1_3,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_1_4,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_1_5,
  input  logic [2:0]                 in_flag_2,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_2_1,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_2_2,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_2_3,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_2_4,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_2_5,
  input  logic                       in_flag_last,
  output logic                       in_ready,
  output logic [BITSTREAM_WIDTH-1:0] out_byte,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_done,
  output logic                       err_flag
`ifdef COLLECTOR_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0]     byte_count
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  lane_desc_t       lane_1, lane_2, wr_data_0, head, cur_q;
  logic             ok_1, ok_2, wr_en_0, wr_en_1, empty, pop, hs, err_set;
  logic [CNT_W-1:0] free_cnt;
  state_e           state_q, next_desc_st;
  logic [7:0]       run_q;
  logic             third_q, last_seen_q, flag_last_q;

  assign lane_1 = '{in_flag_1, in_bit_1_1, in_bit_1_2, in_bit_1_3, in_bit_1_4, in_bit_1_5};
  assign lane_2 = '{in_flag_2, in_bit_2_1, in_bit_2_2, in_bit_2_3, in_bit_2_4, in_bit_2_5};

  assign in_ready = (free_cnt >= CNT_W'(2));
  assign ok_1     = in_ready && lane_legal(in_flag_1);
  assign ok_2     = in_ready && lane_legal(in_flag_2);
  // Compact the write so a lone lane 2 takes the first free slot.
  assign wr_en_0   = ok_1 || ok_2;
  assign wr_en_1   = ok_1 && ok_2;
  assign wr_data_0 = ok_1 ? lane_1 : lane_2;
  assign err_set   = ((in_flag_1 != FLAG_NONE) && ((in_flag_1 == FLAG_ILLEGAL) || !in_ready)) ||
                     ((in_flag_2 != FLAG_NONE) && ((in_flag_2 == FLAG_ILLEGAL) || !in_ready));

  assign pop          = (state_q == StLoad);
  assign hs           = out_valid && out_ready;
  assign next_desc_st = empty ? StIdle : StLoad;

  desc_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .bool_burst_1 (bool_burst_1),
    .wr_en_0      (wr_en_0),
    .wr_data_0    (wr_data_0),
    .wr_en_1      (wr_en_1),
    .wr_data_1    (lane_2),
    .rd_en        (pop),
    .rd_data      (head),
    .empty        (empty),
    .free_cnt     (free_cnt)
  );

  always_ff @(posedge clk or posedge bool_burst_1) begin
    if (bool_burst_1) begin
      state_q   <= StIdle;
      cur_q     <= '0;
      run_q     <= '0;
      third_q   <= 1'b0;
      out_byte  <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: if (!empty) state_q <= StLoad;
        StLoad: begin
          cur_q     <= head;
          out_byte  <= head.b1;
          out_valid <= 1'b1;
          third_q   <= 1'b0;
          state_q   <= StEmitB1;
        end
        StEmitB1: if (hs) begin
          if (cur_q.flag < FLAG_ILLEGAL) begin
            if (cur_q.flag == 3'd1) begin
              out_valid <= 1'b0;
              state_q   <= next_desc_st;
            end else begin
              out_byte <= cur_q.b2;
              state_q  <= StEmitDir;
            end
          end else if (cur_q.b3 != 8'd0) begin
            out_byte <= cur_q.b2;
            run_q    <= cur_q.b3;
            state_q  <= StEmitRun;
          end else if (cur_q.flag >= FLAG_TAIL4) begin
            out_byte <= cur_q.b4;
            state_q  <= StEmitB4;
          end else begin
            out_valid <= 1'b0;
            state_q   <= next_desc_st;
          end
        end
        StEmitDir: if (hs) begin
          if ((cur_q.flag == 3'd3) && !third_q) begin
            out_byte <= cur_q.b3;
            third_q  <= 1'b1;
          end else begin
            out_valid <= 1'b0;
            state_q   <= next_desc_st;
          end
        end
        StEmitRun: if (hs) begin
          run_q <= run_q - 8'd1;
          if (run_q == 8'd1) begin
            if (cur_q.flag >= FLAG_TAIL4) begin
              out_byte <= cur_q.b4;
              state_q  <= StEmitB4;
            end else begin
              out_valid <= 1'b0;
              state_q   <= next_desc_st;
            end
          end
        end
        StEmitB4: if (hs) begin
          if (cur_q.flag == FLAG_TAIL5) begin
            out_byte <= cur_q.b5;
            state_q  <= StEmitB5;
          end else begin
            out_valid <= 1'b0;
            state_q   <= next_desc_st;
          end
        end
        StEmitB5: if (hs) begin
          out_valid <= 1'b0;
          state_q   <= next_desc_st;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Frame end is reported only once everything, including a same-edge write, has drained.
  always_ff @(posedge clk or posedge bool_burst_1) begin
    if (bool_burst_1) begin
      flag_last_q <= 1'b0;
      last_seen_q <= 1'b0;
      out_done    <= 1'b0;
      err_flag    <= 1'b0;
    end else begin
      flag_last_q <= in_flag_last;
      out_done    <= 1'b0;
      if (err_set) err_flag <= 1'b1;
      if (in_flag_last && !flag_last_q) begin
        last_seen_q <= 1'b1;
      end else if (last_seen_q && empty && (state_q == StIdle) && !wr_en_0) begin
        out_done    <= 1'b1;
        last_seen_q <= 1'b0;
      end
    end
  end

`ifdef COLLECTOR_COUNT_EN
  always_ff @(posedge clk or posedge bool_burst_1) begin
    if (bool_burst_1) begin
      byte_count <= '0;
    end else if (hs) begin
      byte_count <= byte_count + COUNT_WIDTH'(1);
    end
  end
`else
  // Counter width is only meaningful in the counted build.
  logic [COUNT_WIDTH-1:0] unused_count;
  assign unused_count = '0;
`endif

endmodule
